// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction-fetch controller.
package ifetch_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FAULT} state_e;
  localparam int IFETCH_QDEPTH = 2;
  localparam logic [31:0] RV_NOP = 32'h0000_0013;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } entry_t;
endpackage

// File: rtl/ifetch_queue.sv
// ifetch_queue: 2-entry prefetch FIFO; the head always lives in slot 0, flush overrides push and pop.
module ifetch_queue
  import ifetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic       flush_i,
  input  entry_t     din_i,
  output logic [1:0] count_o,
  output entry_t     head_o
);
  entry_t e0_q, e0_d, e1_q, e1_d;
  logic [1:0] cnt_q, cnt_d, cnt_p;
  logic pop_v, push_v;
  always_comb begin
    pop_v  = pop_i && cnt_q != 2'd0;
    cnt_p  = cnt_q - {1'b0, pop_v};
    push_v = push_i && cnt_p != 2'(IFETCH_QDEPTH);
    e0_d   = (push_v && cnt_p == 2'd0) ? din_i : pop_v ? e1_q : e0_q;
    e1_d   = (push_v && cnt_p == 2'd1) ? din_i : e1_q;
    cnt_d  = flush_i ? 2'd0 : cnt_p + {1'b0, push_v};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= '0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end
  assign count_o = cnt_q;
  assign head_o  = e0_q;
endmodule

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: PC, fetch FSM and redirect handling in front of a 2-entry prefetch queue.
// Define IFETCH_MISALIGN_EN to turn misaligned redirects into a single fault entry.
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter int          SIZE     = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_en,
  output logic [SIZE-1:0] imem_addr,
  input  logic [31:0]     imem_data,
  input  logic            redirect_valid,
  input  logic [31:0]     redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_pc,
`ifdef IFETCH_MISALIGN_EN
  output logic            out_fault,
`endif
  output logic [31:0]     out_instr
);
  state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, tgt;
  logic [1:0] count;
  logic push, pop, misalign, fault_push;
  entry_t din, head;
`ifdef IFETCH_MISALIGN_EN
  logic pend_q, pend_d;
  assign misalign   = redirect_pc[1:0] != 2'b00;
  assign tgt        = redirect_pc;
  assign fault_push = state_q == FAULT && pend_q;
  assign out_fault  = head.fault;
  // The fault entry is pushed once; FAULT then idles until the next redirect.
  assign pend_d     = redirect_valid ? misalign : pend_q && !fault_push;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= 1'b0;
    else pend_q <= pend_d;
  end
`else
  assign misalign   = 1'b0;
  assign tgt        = redirect_pc & 32'hFFFF_FFFC;
  assign fault_push = 1'b0;
`endif
  always_comb begin
    pop       = out_valid && out_ready;
    push      = !redirect_valid && ((state_q == RUN && (count != 2'(IFETCH_QDEPTH) || pop)) || fault_push);
    din.pc    = pc_q;
    din.instr = fault_push ? RV_NOP : imem_data;
    din.fault = fault_push;
    pc_d      = redirect_valid ? tgt : (push && !fault_push) ? pc_q + 32'd4 : pc_q;
    state_d   = redirect_valid ? (misalign ? FAULT : fetch_en ? RUN : IDLE)
              : state_q == FAULT ? FAULT : fetch_en ? RUN : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end
  ifetch_queue u_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .din_i   (din),
    .count_o (count),
    .head_o  (head)
  );
  assign imem_addr = pc_q[SIZE+1:2];
  assign out_valid = count != 2'd0;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl: directed checks of streaming, stall, redirect, wrap/alias and misaligned redirect.
module tb_ifetch_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b1;
  logic [9:0]  imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_pc, out_instr;
  logic        out_fault;
  logic [3:0]  imem_addr4;
  logic [31:0] imem_data4;
  logic        redirect_valid4 = 1'b0;
  logic [31:0] redirect_pc4 = '0;
  logic        out_valid4;
  logic [31:0] out_pc4, out_instr4;
  logic        out_fault4;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;
  assign imem_data  = 32'hDEAD_0000 + {22'd0, imem_addr};
  assign imem_data4 = 32'hBEEF_0000 + {28'd0, imem_addr4};

  ifetch_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc),
`ifdef IFETCH_MISALIGN_EN
    .out_fault(out_fault),
`endif
    .out_instr(out_instr)
  );

  ifetch_ctrl #(.SIZE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .fetch_en(1'b1), .imem_addr(imem_addr4), .imem_data(imem_data4),
    .redirect_valid(redirect_valid4), .redirect_pc(redirect_pc4), .out_valid(out_valid4),
    .out_ready(1'b1), .out_pc(out_pc4),
`ifdef IFETCH_MISALIGN_EN
    .out_fault(out_fault4),
`endif
    .out_instr(out_instr4)
  );

`ifndef IFETCH_MISALIGN_EN
  assign out_fault  = 1'b0;
  assign out_fault4 = 1'b0;
`endif

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic rdy);
    rst_n = 1'b0;
    fetch_en = 1'b1;
    out_ready = rdy;
    redirect_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0 || out_fault !== 1'b0 || imem_addr !== 10'd0) begin
      failures++;
      $display("FAIL reset got v=%b pc=%h instr=%h f=%b addr=%h want 0 0 0 0 0", out_valid, out_pc, out_instr, out_fault, imem_addr);
    end
    apply_reset(1'b1);
    tick;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL first_edge_valid got=%b want=0", out_valid);
    end
  endtask

  task automatic test_stream;
    tick;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * k) || out_instr !== 32'hDEAD_0000 + 32'(k)) begin
        failures++;
        $display("FAIL stream[%0d] got v=%b pc=%h instr=%h want 1 %h %h", k, out_valid, out_pc, out_instr, 32'(4 * k), 32'hDEAD_0000 + 32'(k));
      end
      tick;
    end
  endtask

  task automatic test_reset_mid;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_pc !== 32'h0 || imem_addr !== 10'd0) begin
      failures++;
      $display("FAIL reset_mid got v=%b pc=%h addr=%h want 0 0 0", out_valid, out_pc, imem_addr);
    end
  endtask

  task automatic test_stall;
    apply_reset(1'b0);
    repeat (6) tick;
    checks++;
    if (imem_addr !== 10'd2 || out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'hDEAD_0000) begin
      failures++;
      $display("FAIL stall_hold got addr=%h v=%b pc=%h instr=%h want 2 1 0 dead0000", imem_addr, out_valid, out_pc, out_instr);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * k) || out_instr !== 32'hDEAD_0000 + 32'(k)) begin
        failures++;
        $display("FAIL stall_release[%0d] got v=%b pc=%h instr=%h want 1 %h %h", k, out_valid, out_pc, out_instr, 32'(4 * k), 32'hDEAD_0000 + 32'(k));
      end
      tick;
    end
  endtask

  task automatic test_redirect(input logic rdy);
    apply_reset(1'b0);
    repeat (4) tick;
    out_ready = rdy;
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    tick;
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || imem_addr !== 10'h10) begin
      failures++;
      $display("FAIL redirect_gap(rdy=%b) got v=%b addr=%h want 0 010", rdy, out_valid, imem_addr);
    end
    for (int k = 0; k < 2; k++) begin
      tick;
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h40 + 32'(4 * k) || out_instr !== 32'hDEAD_0010 + 32'(k)) begin
        failures++;
        $display("FAIL redirect_head(rdy=%b)[%0d] got v=%b pc=%h instr=%h want 1 %h %h", rdy, k, out_valid, out_pc, out_instr, 32'h40 + 32'(4 * k), 32'hDEAD_0010 + 32'(k));
      end
    end
  endtask

  task automatic test_wrap;
    logic [31:0] exp_pc [3];
    logic [31:0] exp_in [3];
    exp_pc = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
    exp_in = '{32'hDEAD_03FE, 32'hDEAD_03FF, 32'hDEAD_0000};
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    tick;
    redirect_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick;
      checks++;
      if (out_valid !== 1'b1 || out_pc !== exp_pc[k] || out_instr !== exp_in[k]) begin
        failures++;
        $display("FAIL wrap[%0d] got v=%b pc=%h instr=%h want 1 %h %h", k, out_valid, out_pc, out_instr, exp_pc[k], exp_in[k]);
      end
    end
  endtask

  task automatic test_alias;
    logic [31:0] exp_pc [3];
    logic [31:0] exp_in [3];
    exp_pc = '{32'h38, 32'h3C, 32'h40};
    exp_in = '{32'hBEEF_000E, 32'hBEEF_000F, 32'hBEEF_0000};
    redirect_valid4 = 1'b1;
    redirect_pc4 = 32'h38;
    tick;
    redirect_valid4 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick;
      checks++;
      if (out_valid4 !== 1'b1 || out_pc4 !== exp_pc[k] || out_instr4 !== exp_in[k]) begin
        failures++;
        $display("FAIL alias[%0d] got v=%b pc=%h instr=%h want 1 %h %h", k, out_valid4, out_pc4, out_instr4, exp_pc[k], exp_in[k]);
      end
      if (k == 1) begin
        checks++;
        if (imem_addr4 !== 4'd0) begin
          failures++;
          $display("FAIL alias_addr got=%h want=0", imem_addr4);
        end
      end
    end
  endtask

  task automatic test_misalign;
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h102;
    tick;
    redirect_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL misalign_gap got v=%b want 0", out_valid);
    end
    tick;
`ifdef IFETCH_MISALIGN_EN
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h102 || out_instr !== 32'h13 || out_fault !== 1'b1) begin
      failures++;
      $display("FAIL misalign_head got v=%b pc=%h instr=%h f=%b want 1 102 13 1", out_valid, out_pc, out_instr, out_fault);
    end
    for (int k = 0; k < 3; k++) begin
      tick;
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL fault_idle[%0d] got v=%b want 0", k, out_valid);
      end
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    tick;
    redirect_valid = 1'b0;
    tick;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_instr !== 32'hDEAD_0040 || out_fault !== 1'b0) begin
      failures++;
      $display("FAIL fault_resume got v=%b pc=%h instr=%h f=%b want 1 100 dead0040 0", out_valid, out_pc, out_instr, out_fault);
    end
`else
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_instr !== 32'hDEAD_0040) begin
      failures++;
      $display("FAIL align_force got v=%b pc=%h instr=%h want 1 100 dead0040", out_valid, out_pc, out_instr);
    end
`endif
  endtask

  initial begin
    test_reset;
    test_stream;
    test_reset_mid;
    test_stall;
    test_redirect(1'b0);
    test_redirect(1'b1);
    test_wrap;
    test_alias;
    test_misalign;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
